// File: rtl/weight_bram_pkg.sv
// rtl/weight_bram_pkg.sv - shared constants, FSM state and typedefs for the weight BRAM loader
package weight_bram_pkg;

    localparam int WGT_DEPTH  = 8192;
    localparam int WGT_WORD_W = 32;
    localparam int WGT_LINE_W = 128;
    localparam int WGT_LANES  = WGT_LINE_W / WGT_WORD_W;
    localparam int WGT_ADDR_W = $clog2(WGT_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } loader_state_t;

    typedef logic [WGT_ADDR_W-1:0] wgt_line_addr_t;
    typedef logic [WGT_LINE_W-1:0] wgt_line_t;

endpackage

// File: rtl/word_line_packer.sv
// rtl/word_line_packer.sv - packs accepted stream words into lanes of one BRAM line
//
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   in_valid       a word is accepted this cycle
//   in_last        the accepted word is the last of the job
//   in_data        accepted word
//   line_complete  combinational: this acceptance closes the current line
//   line_strobe    registered: packed line is on line_data this cycle
//   line_data      last completed line (holds between strobes)
module word_line_packer #(
    parameter int WORD_W = 32,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              in_last,
    input  logic [WORD_W-1:0] in_data,
    output logic              line_complete,
    output logic              line_strobe,
    output logic [LINE_W-1:0] line_data
);

    localparam int LANES  = LINE_W / WORD_W;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    logic [LANE_W-1:0] lane;
    logic [LINE_W-1:0] pack_reg;
    logic [LINE_W-1:0] merged;

    // Lane n occupies [n*WORD_W +: WORD_W] so the read side's byte-address
    // bits [3:2] select the same word that was written in that position.
    always_comb begin
        merged = pack_reg;
        merged[lane*WORD_W +: WORD_W] = in_data;
    end

    assign line_complete = in_valid && (in_last || (lane == LANE_W'(LANES - 1)));

    // The completed line moves to line_data in the acceptance cycle, so the
    // pack register is free to take the next word on the following cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lane        <= '0;
            pack_reg    <= '0;
            line_strobe <= 1'b0;
            line_data   <= '0;
        end else begin
            line_strobe <= line_complete;
            if (in_valid) begin
                if (line_complete) begin
                    line_data <= merged;
                    pack_reg  <= '0;
                    lane      <= '0;
                end else begin
                    pack_reg  <= merged;
                    lane      <= lane + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/weight_bram_loader.sv
// rtl/weight_bram_loader.sv - fills the 128-bit weight BRAM from a 32-bit word stream
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start               one-cycle job launch, honoured only in IDLE
//   base_addr           first line written, sampled on start
//   num_words           words in the job, sampled on start
//   s_valid/s_data      incoming word stream
//   s_ready             loader takes a word this cycle
//   wr_rd_en            BRAM write enable, one cycle per line
//   wr_addr/wr_data     BRAM line address and packed line
//   busy                job in progress
//   done                one-cycle completion pulse
module weight_bram_loader
    import weight_bram_pkg::*;
#(
    parameter int DEPTH  = WGT_DEPTH,
    parameter int WORD_W = WGT_WORD_W,
    parameter int LINE_W = WGT_LINE_W,
    parameter int CNT_W  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  num_words,
    input  logic              s_valid,
    input  logic [WORD_W-1:0] s_data,
    output logic              s_ready,
    output logic              wr_rd_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [LINE_W-1:0] wr_data,
    output logic              busy,
    output logic              done
);

    loader_state_t     state;
    loader_state_t     state_nxt;
    logic [ADDR_W-1:0] line_ptr;
    logic [CNT_W-1:0]  remaining;
    logic              accept;
    logic              last_word;
    logic              line_complete;

    assign accept    = s_valid && s_ready;
    assign last_word = (remaining == CNT_W'(1));

    word_line_packer #(
        .WORD_W (WORD_W),
        .LINE_W (LINE_W)
    ) u_packer (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (accept),
        .in_last       (last_word),
        .in_data       (s_data),
        .line_complete (line_complete),
        .line_strobe   (wr_rd_en),
        .line_data     (wr_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (start) state_nxt = (num_words != '0) ? LOAD : DONE;
            LOAD:  if (accept && last_word) state_nxt = FLUSH;
            FLUSH: state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        s_ready = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state)
            LOAD:  begin s_ready = 1'b1; busy = 1'b1; end
            FLUSH: busy = 1'b1;
            DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // The write address is captured alongside the packed line, so it lines
    // up with wr_rd_en one cycle after the completing word is accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            line_ptr  <= '0;
            remaining <= '0;
            wr_addr   <= '0;
        end else begin
            if (state == IDLE && start) begin
                line_ptr  <= base_addr;
                remaining <= num_words;
            end
            if (accept) begin
                remaining <= remaining - 1'b1;
            end
            if (line_complete) begin
                wr_addr  <= line_ptr;
                line_ptr <= (line_ptr == ADDR_W'(DEPTH - 1)) ? '0 : line_ptr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_weight_bram_loader.sv
// tb/tb_weight_bram_loader.sv - table-driven self-checking bench for weight_bram_loader
module tb_weight_bram_loader;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [12:0]   base_addr = '0;
    logic [15:0]   num_words = '0;
    logic          s_valid = 1'b0;
    logic [31:0]   s_data = '0;
    logic          s_ready;
    logic          wr_rd_en;
    logic [12:0]   wr_addr;
    logic [127:0]  wr_data;
    logic          busy;
    logic          done;

    weight_bram_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .num_words (num_words),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .wr_rd_en  (wr_rd_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [12:0]        base;
        logic [15:0]        n;
        logic [31:0]        w0;
        bit                 rnd;
        int                 nlines;
        logic [2:0][12:0]   addr;
        logic [2:0][127:0]  line;
    } job_t;

    job_t jobs[5];

    function automatic job_t mk(input logic [12:0] base, input logic [15:0] n, input logic [31:0] w0,
                                input bit rnd, input int nl,
                                input logic [12:0] a0, input logic [12:0] a1, input logic [12:0] a2,
                                input logic [127:0] l0, input logic [127:0] l1, input logic [127:0] l2);
        job_t j;
        j.base = base; j.n = n; j.w0 = w0; j.rnd = rnd; j.nlines = nl;
        j.addr[0] = a0; j.addr[1] = a1; j.addr[2] = a2;
        j.line[0] = l0; j.line[1] = l1; j.line[2] = l2;
        return j;
    endfunction

    task automatic run_job(input job_t j, input string tag);
        int  widx = 0, wcnt = 0, done_cyc = -1, start_cyc, last_t = -1;
        int  rdy_cnt = 0, busy_hi = 0, prev_wr = 0;
        bit  hs = 0, fin = 0, pulsed = 0;
        @(negedge clk);
        start = 1'b1; base_addr = j.base; num_words = j.n; start_cyc = cyc;
        fork
            begin
                while (!fin) begin
                    @(negedge clk);
                    start = 1'b0; base_addr = '0; num_words = '0;
                    if (hs) begin
                        if (widx == int'(j.n) - 1) last_t = cyc - 1;
                        widx++;
                    end
                    if (widx < int'(j.n)) begin
                        s_valid = j.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                        s_data  = j.w0 + 32'(widx);
                    end else begin
                        s_valid = 1'b1;
                        s_data  = 32'hDEADBEEF;
                    end
                    if (j.rnd && widx == 5 && !pulsed) begin
                        start = 1'b1; base_addr = 13'd5; num_words = 16'd3; pulsed = 1;
                    end
                    hs = s_valid && s_ready;
                end
                s_valid = 1'b0;
            end
            begin
                for (int k = 0; k < 400 && !fin; k++) begin
                    @(negedge clk);
                    if (s_ready) rdy_cnt++;
                    if (busy) busy_hi++;
                    if (wr_rd_en) begin
                        if (wcnt < j.nlines) begin
                            chk({tag, "_addr"}, 128'(wr_addr), 128'(j.addr[wcnt]));
                            chk({tag, "_data"}, wr_data, j.line[wcnt]);
                            if (wcnt > 0 && !j.rnd && j.n[1:0] == 2'b00)
                                chk({tag, "_gap"}, 128'(cyc - prev_wr), 128'(4));
                        end
                        prev_wr = cyc;
                        wcnt++;
                    end
                    if (done) begin
                        done_cyc = cyc;
                        fin = 1;
                    end
                end
                chk({tag, "_done_seen"}, 128'(fin), 128'(1));
                fin = 1;
            end
        join
        chk({tag, "_nwrites"}, 128'(wcnt), 128'(j.nlines));
        if (j.n != 0)
            chk({tag, "_done_lat"}, 128'(done_cyc - last_t), 128'(2));
        else
            chk({tag, "_done_lat"}, 128'(done_cyc - start_cyc), 128'(1));
        if (!j.rnd)
            chk({tag, "_rdy_cycles"}, 128'(rdy_cnt), 128'(j.n));
        chk({tag, "_busy_cycles"}, 128'(busy_hi), 128'(done_cyc - start_cyc - 1));
        @(negedge clk);
        chk({tag, "_post"}, 128'({done, busy, s_ready, wr_rd_en}), 128'(0));
    endtask

    initial begin
        jobs[0] = mk(13'd10, 16'd8, 32'h1, 0, 2, 13'd10, 13'd11, 13'd0,
                     128'h00000004_00000003_00000002_00000001,
                     128'h00000008_00000007_00000006_00000005, 128'h0);
        jobs[1] = mk(13'd0, 16'd6, 32'hA1, 0, 2, 13'd0, 13'd1, 13'd0,
                     128'h000000A4_000000A3_000000A2_000000A1,
                     128'h00000000_00000000_000000A6_000000A5, 128'h0);
        jobs[2] = mk(13'd8191, 16'd8, 32'h11, 0, 2, 13'd8191, 13'd0, 13'd0,
                     128'h00000014_00000013_00000012_00000011,
                     128'h00000018_00000017_00000016_00000015, 128'h0);
        jobs[3] = mk(13'd50, 16'd0, 32'h0, 0, 0, 13'd0, 13'd0, 13'd0, 128'h0, 128'h0, 128'h0);
        jobs[4] = mk(13'd100, 16'd12, 32'h21, 1, 3, 13'd100, 13'd101, 13'd102,
                     128'h00000024_00000023_00000022_00000021,
                     128'h00000028_00000027_00000026_00000025,
                     128'h0000002C_0000002B_0000002A_00000029);

        // Reset state
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_ctrl", 128'({done, busy, s_ready, wr_rd_en}), 128'(0));
        chk("rst_addr", 128'(wr_addr), 128'(0));
        chk("rst_data", wr_data, 128'(0));

        for (int i = 0; i < 5; i++) begin
            run_job(jobs[i], $sformatf("job%0d", i));
        end

        // start during the DONE cycle must be ignored
        @(negedge clk);
        start = 1'b1; base_addr = 13'd3; num_words = 16'd0;
        @(negedge clk);
        chk("zero_done", 128'(done), 128'(1));
        start = 1'b1; base_addr = 13'd3; num_words = 16'd4;
        @(negedge clk);
        start = 1'b0; num_words = '0;
        chk("start_in_done_ignored", 128'({busy, s_ready, done}), 128'(0));

        // Reset after word 2 of 8 abandons the job
        @(negedge clk);
        start = 1'b1; base_addr = 13'd20; num_words = 16'd8;
        @(negedge clk);
        start = 1'b0; num_words = '0; base_addr = '0;
        s_valid = 1'b1; s_data = 32'h1;
        @(negedge clk);
        s_data = 32'h2;
        @(negedge clk);
        s_valid = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_ctrl", 128'({done, busy, s_ready, wr_rd_en}), 128'(0));
        chk("midrst_addr", 128'(wr_addr), 128'(0));
        chk("midrst_data", wr_data, 128'(0));
        begin
            int stray = 0;
            repeat (8) begin
                @(negedge clk);
                if (wr_rd_en || done || busy) stray++;
            end
            chk("midrst_quiet", 128'(stray), 128'(0));
        end

        run_job(jobs[0], "fresh");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
